// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------
// lsu_pkg : funct3 codes and FSM state type for the load/store unit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    RESP  = 2'd2
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------
// lsu_align : load extraction, store lane merge and access check
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  input  logic                  is_store,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged,
  output logic                  fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        legal;
  logic        misaligned;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      F3_W:    load_data = word;
      default: load_data = '0;
    endcase
  end

  // Untouched lanes keep the word read from memory; SW passes wdata straight through.
  always_comb begin
    merged = wdata;
    case (funct3)
      F3_B: begin
        merged = word;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        merged = word;
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  always_comb begin
    if (is_store) legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else          legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                          (funct3 == F3_BU) || (funct3 == F3_HU);
    misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0]) ||
                 ((funct3 == F3_W) && (addr_lo != 2'b00));
    fault      = ~legal | misaligned;
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------
// load_store_unit : RV32I load/store to word-wide memory with RMW sub-word stores
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  fault,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  lsu_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [2:0]            funct3_q;
  logic                  is_store_q;
  logic                  fault_q;

  logic                  in_idle;
  logic                  accept;
  logic [DATA_WIDTH-1:0] al_word;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [1:0]            al_lo;
  logic [2:0]            al_funct3;
  logic                  al_store;
  logic [DATA_WIDTH-1:0] al_load;
  logic [DATA_WIDTH-1:0] al_merged;
  logic                  al_fault;

  assign in_idle = (state == IDLE);
  assign accept  = in_idle & req;

  // One aligner serves both phases: live inputs while idle, latched operands in MERGE.
  assign al_word   = in_idle ? mem_rd   : buf_q;
  assign al_wdata  = in_idle ? wdata    : wdata_q;
  assign al_lo     = in_idle ? addr[1:0] : addr_q[1:0];
  assign al_funct3 = in_idle ? funct3   : funct3_q;
  assign al_store  = in_idle ? is_store : is_store_q;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .word      (al_word),
    .wdata     (al_wdata),
    .addr_lo   (al_lo),
    .funct3    (al_funct3),
    .is_store  (al_store),
    .load_data (al_load),
    .merged    (al_merged),
    .fault     (al_fault)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      buf_q      <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            funct3_q   <= funct3;
            is_store_q <= is_store;
            fault_q    <= al_fault;
            buf_q      <= mem_rd;
            rdata_q    <= (al_fault | is_store) ? '0 : al_load;
            state      <= (!al_fault && is_store && funct3 != F3_W) ? MERGE : RESP;
          end
        end
        MERGE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_a  = in_idle ? {addr[ADDR_WIDTH-1:2], 2'b00} : {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wd = al_merged;
  assign mem_we = rst_n & ((accept & is_store & (funct3 == F3_W) & ~al_fault) | (state == MERGE));
  assign done   = rst_n & (state == RESP);
  assign fault  = done & fault_q;
  assign rdata  = rdata_q;
  assign busy   = req & ~done;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------
// tb_load_store_unit : randomized bench with a transaction-level memory model
// Rev 1.0
// ---------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic        done, fault, busy, mem_we;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .fault(fault),
    .busy(busy), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  logic [31:0] ram   [16];
  logic [31:0] model [16];
  assign mem_rd = ram[mem_a[5:2]];
  always @(posedge clk) if (mem_we) ram[mem_a[5:2]] <= mem_wd;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;
  logic exp_done = 0, exp_fault = 0, exp_we = 0, exp_acc = 0;
  logic [31:0] exp_rdata = '0, exp_wd = '0, exp_a = '0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference rules, written from the ISA semantics.
  function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [1:0] lo);
    bit ok = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    bit half = (f3 == 3'd1) || (f3 == 3'd5);
    return !ok || (half && lo[0]) || (f3 == 3'd2 && lo != 2'd0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] s = w >> (8 * lo);
    case (f3)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd4:    return {24'd0, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd5:    return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    int sh = 8 * lo;
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("fault", {31'd0, fault}, {31'd0, exp_done & exp_fault});
      chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      chk("busy", {31'd0, busy}, {31'd0, req & ~exp_done});
      if (exp_we) begin
        chk("mem_wd", mem_wd, exp_wd);
        chk("mem_a_wr", mem_a, exp_a);
      end
      if (exp_acc) chk("mem_a_acc", mem_a, exp_a);
      if (exp_done) begin
        chk("rdata", rdata, exp_rdata);
        last_rdata = rdata;
      end
    end
  end

  task automatic scramble();
    addr   = $urandom;
    wdata  = $urandom;
    funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req = 0; exp_acc = 0; exp_we = 0; exp_done = 0;
    end
  endtask

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit drop);
    int idx = int'(a[5:2]);
    bit flt = m_fault(st, f3, a[1:0]);
    logic [31:0] res = (flt || st) ? 32'd0 : m_load(model[idx], f3, a[1:0]);
    @(posedge clk); #1;
    req = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    exp_acc = 1; exp_done = 0; exp_a = {a[31:2], 2'b00};
    exp_we = !flt && st && (f3 == 3'd2); exp_wd = wd;
    if (!flt && st) begin
      if (f3 != 3'd2) begin
        @(posedge clk); #1;
        if (drop) req = 0;
        scramble();
        exp_acc = 0; exp_we = 1; exp_wd = m_merge(model[idx], wd, f3, a[1:0]);
      end
      model[idx] = m_merge(model[idx], wd, f3, a[1:0]);
    end
    @(posedge clk); #1;
    if (drop) req = 0;
    scramble();
    exp_acc = 0; exp_we = 0; exp_done = 1; exp_fault = flt; exp_rdata = res;
  endtask

  task automatic rst_merge(input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    req = 1; is_store = 1; funct3 = 3'd0; addr = a; wdata = wd;
    exp_acc = 1; exp_we = 0; exp_done = 0; exp_a = {a[31:2], 2'b00};
    @(posedge clk); #1;
    rst_n = 0; req = 0; exp_acc = 0; exp_we = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("rst_merge_mem", ram[a[5:2]], model[a[5:2]]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v = (i == 0) ? 32'h80FF7F01 : $urandom;
      ram[i] <= v;
      model[i] = v;
    end
    rst_n = 0;
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    do_req(0, 3'd0, 32'h10003, $urandom, 0); idle(1); chk("lb_lit",  last_rdata, 32'hFFFFFF80);
    do_req(0, 3'd4, 32'h10003, $urandom, 0); idle(1); chk("lbu_lit", last_rdata, 32'h00000080);
    do_req(0, 3'd1, 32'h10000, $urandom, 0); idle(1); chk("lh_lit",  last_rdata, 32'h00007F01);
    do_req(0, 3'd5, 32'h10002, $urandom, 0); idle(1); chk("lhu_lit", last_rdata, 32'h000080FF);

    do_req(1, 3'd2, 32'h10000, 32'h11223344, 0); idle(1);
    do_req(1, 3'd0, 32'h10001, 32'hAABBCCDD, 0); idle(1); chk("sb_lit", ram[0], 32'h1122DD44);
    do_req(1, 3'd2, 32'h10000, 32'h11223344, 0); idle(1);
    do_req(1, 3'd1, 32'h10002, 32'h0000BEEF, 0); idle(1); chk("sh_lit", ram[0], 32'hBEEF3344);
    do_req(1, 3'd2, 32'h10004, 32'hCAFEF00D, 0); idle(1); chk("sw_lit", ram[1], 32'hCAFEF00D);

    do_req(0, 3'd2, 32'h10002, $urandom, 0); idle(1); chk("lw_mis_rdata", last_rdata, 32'd0);
    do_req(1, 3'd1, 32'h10001, $urandom, 0); idle(1);
    do_req(0, 3'd3, 32'h10000, $urandom, 0); idle(1);
    chk("fault_mem_kept", ram[0], 32'hBEEF3344);

    do_req(1, 3'd2, 32'h10008, 32'h01020304, 0);
    do_req(0, 3'd2, 32'h10008, $urandom, 0);
    do_req(1, 3'd0, 32'h1000A, 32'h0000005A, 0);
    do_req(0, 3'd2, 32'h10008, $urandom, 0);
    idle(1); chk("b2b_lit", last_rdata, 32'h015A0304);

    idle(1);
    rst_merge(32'h1000D, 32'h000000EE);
    do_req(0, 3'd2, 32'h1000C, $urandom, 0); idle(1);
    do_req(1, 3'd1, 32'h1000E, $urandom, 1); idle(2);

    for (int n = 0; n < 400; n++) begin
      bit st = 1'($urandom_range(0, 1));
      logic [2:0] f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                                    : 3'($urandom_range(0, 2));
      logic [31:0] a = 32'h10000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if (!st && $urandom_range(0, 2) == 0) f3 = f3 | 3'd4;
      do_req(st, f3, a, $urandom, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);
    for (int i = 0; i < 16; i++) chk("final_mem", ram[i], model[i]);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
